// File: rtl/treino_controlador_pkg.sv
// Shared constants and state encoding for the perceptron training sequencer.
package treino_controlador_pkg;

  localparam logic [15:0] H_UM   = 16'h3C00;
  localparam logic [15:0] H_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    APLICA    = 3'd2,
    AVALIA    = 3'd3,
    FIM_EPOCA = 3'd4,
    DONE      = 3'd5
  } estado_t;

  function automatic logic [15:0] bit2half(input logic b);
    return b ? H_UM : H_ZERO;
  endfunction

endpackage

// File: rtl/treino_controlador_sel_amostra.sv
// Picks sample idx out of the truth-table bit vectors and encodes it as half floats.
module treino_controlador_sel_amostra
  import treino_controlador_pkg::*;
(
  input  logic [3:0]  in1_bits_i,
  input  logic [3:0]  in2_bits_i,
  input  logic [3:0]  d_bits_i,
  input  logic [1:0]  idx_i,
  output logic [15:0] in1_o,
  output logic [15:0] in2_o,
  output logic [15:0] d_o
);

  assign in1_o = bit2half(in1_bits_i[idx_i]);
  assign in2_o = bit2half(in2_bits_i[idx_i]);
  assign d_o   = bit2half(d_bits_i[idx_i]);

endmodule

// File: rtl/treino_controlador.sv
// Epoch sequencer driving the single-sample perceptron step until convergence or MAX_EPOCAS.
// Optional ATUALIZA_SO_ERRO_EN: write back weights only on misclassified samples.
module treino_controlador
  import treino_controlador_pkg::*;
#(
  parameter int MAX_EPOCAS = 32,
  parameter int CNT_W      = 6,
  parameter int LAT        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       in1_bits,
  input  logic [3:0]       in2_bits,
  input  logic [3:0]       d_bits,
  input  logic [15:0]      u,
  input  logic [15:0]      w0_ini,
  input  logic [15:0]      w1_ini,
  input  logic [15:0]      w2_ini,
  output logic [15:0]      ep_in1,
  output logic [15:0]      ep_in2,
  output logic [15:0]      ep_d,
  output logic [15:0]      ep_u,
  output logic [15:0]      ep_w0,
  output logic [15:0]      ep_w1,
  output logic [15:0]      ep_w2,
  input  logic [15:0]      ep_result,
  input  logic [15:0]      ep_w0_aux,
  input  logic [15:0]      ep_w1_aux,
  input  logic [15:0]      ep_w2_aux,
  output logic             busy,
  output logic             done,
  output logic             convergiu,
  output logic [CNT_W-1:0] epoca_cnt,
  output logic [2:0]       erros_ult
);

  localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

  estado_t          state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [LAT_W-1:0] lat_q;
  logic [2:0]       acc_q, erros_q;
  logic [CNT_W-1:0] cnt_q;
  logic             conv_q;
  logic [15:0]      w0_q, w1_q, w2_q;
  logic [15:0]      in1_q, in2_q, d_q, u_q;
  logic [15:0]      smp_in1, smp_in2, smp_d;
  logic             erro, lat_fim, ultima;

  assign erro    = (ep_result != d_q);
  assign lat_fim = (lat_q == LAT_W'(LAT - 1));
  assign ultima  = ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_EPOCAS));

  // idx advances as AVALIA retires a sample; it wraps to 0 naturally after sample 3
  always_comb begin
    idx_d = idx_q;
    if (state_q == LOAD)        idx_d = 2'd0;
    else if (state_q == AVALIA) idx_d = idx_q + 2'd1;
  end

  treino_controlador_sel_amostra u_sel_amostra (
    .in1_bits_i (in1_bits),
    .in2_bits_i (in2_bits),
    .d_bits_i   (d_bits),
    .idx_i      (idx_d),
    .in1_o      (smp_in1),
    .in2_o      (smp_in2),
    .d_o        (smp_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       state_d = APLICA;
      APLICA:     if (lat_fim) state_d = AVALIA;
      AVALIA:     state_d = (idx_q == 2'd3) ? FIM_EPOCA : APLICA;
      FIM_EPOCA:  state_d = ((acc_q == 3'd0) || ultima) ? DONE : APLICA;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == LOAD) || (state_q == APLICA) ||
           (state_q == AVALIA) || (state_q == FIM_EPOCA);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      lat_q   <= '0;
      acc_q   <= '0;
      erros_q <= '0;
      cnt_q   <= '0;
      conv_q  <= 1'b0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      d_q     <= '0;
      u_q     <= '0;
    end else begin
      idx_q <= idx_d;
      case (state_q)
        IDLE, DONE: if (start) conv_q <= 1'b0;
        LOAD: begin
          w0_q  <= w0_ini;
          w1_q  <= w1_ini;
          w2_q  <= w2_ini;
          cnt_q <= '0;
          acc_q <= '0;
          lat_q <= '0;
        end
        APLICA: lat_q <= lat_fim ? '0 : lat_q + LAT_W'(1);
        AVALIA: begin
          if (erro) acc_q <= acc_q + 3'd1;
`ifdef ATUALIZA_SO_ERRO_EN
          if (erro) begin
            w0_q <= ep_w0_aux;
            w1_q <= ep_w1_aux;
            w2_q <= ep_w2_aux;
          end
`else
          w0_q <= ep_w0_aux;
          w1_q <= ep_w1_aux;
          w2_q <= ep_w2_aux;
`endif
        end
        FIM_EPOCA: begin
          erros_q <= acc_q;
          cnt_q   <= cnt_q + CNT_W'(1);
          acc_q   <= '0;
          conv_q  <= (acc_q == 3'd0);
        end
        default: ;
      endcase
      // Sample is latched on entry to APLICA so it is stable for all LAT cycles and AVALIA
      if (state_d == APLICA && state_q != APLICA) begin
        in1_q <= smp_in1;
        in2_q <= smp_in2;
        d_q   <= smp_d;
        u_q   <= u;
      end
    end
  end

  assign ep_in1    = in1_q;
  assign ep_in2    = in2_q;
  assign ep_d      = d_q;
  assign ep_u      = u_q;
  assign ep_w0     = w0_q;
  assign ep_w1     = w1_q;
  assign ep_w2     = w2_q;
  assign convergiu = conv_q;
  assign epoca_cnt = cnt_q;
  assign erros_ult = erros_q;

endmodule

// File: tb/tb_treino_controlador.sv
// Self-checking bench for treino_controlador with stub and behavioural perceptron steps.
module tb_treino_controlador;
  import treino_controlador_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  in1_bits, in2_bits, d_bits;
  logic [15:0] u, w0_ini, w1_ini, w2_ini;
  logic [15:0] ep_in1, ep_in2, ep_d, ep_u, ep_w0, ep_w1, ep_w2;
  logic [15:0] ep_result, ep_w0_aux, ep_w1_aux, ep_w2_aux;
  logic        busy, done, convergiu;
  logic [5:0]  epoca_cnt;
  logic [2:0]  erros_ult;
  int          mode;
  int          checks = 0;
  int          failures = 0;

  treino_controlador dut (
    .clk(clk), .reset(reset), .start(start),
    .in1_bits(in1_bits), .in2_bits(in2_bits), .d_bits(d_bits), .u(u),
    .w0_ini(w0_ini), .w1_ini(w1_ini), .w2_ini(w2_ini),
    .ep_in1(ep_in1), .ep_in2(ep_in2), .ep_d(ep_d), .ep_u(ep_u),
    .ep_w0(ep_w0), .ep_w1(ep_w1), .ep_w2(ep_w2),
    .ep_result(ep_result), .ep_w0_aux(ep_w0_aux), .ep_w1_aux(ep_w1_aux), .ep_w2_aux(ep_w2_aux),
    .busy(busy), .done(done), .convergiu(convergiu), .epoca_cnt(epoca_cnt), .erros_ult(erros_ult)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    v = (h[14:10] == 5'd0) ? real'(h[9:0]) / 1024.0 : 1.0 + real'(h[9:0]) / 1024.0;
    e = (h[14:10] == 5'd0) ? -14 : int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  a;
    int   e, m;
    logic s;
    logic [9:0] mm;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    mm = m[9:0];
    return {s, 5'(e), mm};
  endfunction

  function automatic logic step_y(input logic [15:0] w0, w1, w2, x1, x2);
    real net;
    net = h2r(w0) + h2r(w1) * h2r(x1) + h2r(w2) * h2r(x2);
    return net > 0.0;
  endfunction

  function automatic logic [15:0] upd(input logic [15:0] w, lr, x, input logic d, y);
    return r2h(h2r(w) + h2r(lr) * (real'(int'(d)) - real'(int'(y))) * h2r(x));
  endfunction

  // Stand-in for the perceptron step; mode picks the behaviour under test
  logic yv, dv;
  always_comb begin
    ep_result = ep_d;
    ep_w0_aux = ep_w0;
    ep_w1_aux = ep_w1;
    ep_w2_aux = ep_w2;
    yv = step_y(ep_w0, ep_w1, ep_w2, ep_in1, ep_in2);
    dv = (ep_d == H_UM);
    case (mode)
      1: ep_result = (ep_d == H_UM) ? H_ZERO : H_UM;
      2: begin
        ep_result = yv ? H_UM : H_ZERO;
        ep_w0_aux = upd(ep_w0, ep_u, H_UM, dv, yv);
        ep_w1_aux = upd(ep_w1, ep_u, ep_in1, dv, yv);
        ep_w2_aux = upd(ep_w2, ep_u, ep_in2, dv, yv);
      end
      3: begin
        ep_w0_aux = 16'h4000;
        ep_w1_aux = 16'h4000;
        ep_w2_aux = 16'h4000;
      end
      default: ;
    endcase
  end

  typedef struct {
    int          mode;
    logic [3:0]  a, b, d;
    logic [15:0] w0, w1, w2;
    int          cyc;
    logic        conv;
    int          cnt, err;
    logic [15:0] ew0, ew1, ew2;
  } vec_t;

  vec_t tbl[4];
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic run(input int pulse_at, output int n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_load", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 2000) begin
      start = (n == pulse_at);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=%0d required=done", n);
    end
  endtask

  task automatic apply(input vec_t v, input int pulse_at);
    vec_t e;
    int   n;
    mode = v.mode; in1_bits = v.a; in2_bits = v.b; d_bits = v.d;
    u = 16'h3800; w0_ini = v.w0; w1_ini = v.w1; w2_ini = v.w2;
    exp_q.push_back(v);
    run(pulse_at, n);
    e = exp_q.pop_front();
    chk("cycles", n, e.cyc);
    chk("convergiu", {31'd0, convergiu}, {31'd0, e.conv});
    chk("epoca_cnt", {26'd0, epoca_cnt}, e.cnt);
    chk("erros_ult", {29'd0, erros_ult}, e.err);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("w0", {16'd0, ep_w0}, {16'd0, e.ew0});
    chk("w1", {16'd0, ep_w1}, {16'd0, e.ew1});
    chk("w2", {16'd0, ep_w2}, {16'd0, e.ew2});
  endtask

  initial begin
    int n;
    tbl[0] = '{0, 4'b0101, 4'b0011, 4'b0111, 16'h1234, 16'h5678, 16'h9ABC, 10, 1'b1, 1, 0,
               16'h1234, 16'h5678, 16'h9ABC};
    tbl[1] = '{1, 4'b0101, 4'b0011, 4'b0111, 16'h0000, 16'h0000, 16'h0000, 289, 1'b0, 32, 4,
               16'h0000, 16'h0000, 16'h0000};
`ifdef ATUALIZA_SO_ERRO_EN
    tbl[2] = '{3, 4'b0101, 4'b0011, 4'b0111, 16'h1111, 16'h2222, 16'h3333, 10, 1'b1, 1, 0,
               16'h1111, 16'h2222, 16'h3333};
`else
    tbl[2] = '{3, 4'b0101, 4'b0011, 4'b0111, 16'h1111, 16'h2222, 16'h3333, 10, 1'b1, 1, 0,
               16'h4000, 16'h4000, 16'h4000};
`endif
    tbl[3] = '{0, 4'b0101, 4'b0011, 4'b0001, 16'h0ABC, 16'h0000, 16'hC000, 10, 1'b1, 1, 0,
               16'h0ABC, 16'h0000, 16'hC000};

    reset = 1'b0; start = 1'b0; mode = 0;
    in1_bits = '0; in2_bits = '0; d_bits = '0; u = '0; w0_ini = '0; w1_ini = '0; w2_ini = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_conv", {31'd0, convergiu}, 32'd0);
    chk("rst_cnt", {26'd0, epoca_cnt}, 32'd0);
    chk("rst_ep_w0", {16'd0, ep_w0}, 32'd0);
    #12 reset = 1'b1;

    for (int i = 0; i < 4; i++) apply(tbl[i], -1);

    // Sample presentation: after edges 2,4,6,8 the step sees samples 0..3
    mode = 0; in1_bits = 4'b0101; in2_bits = 4'b0011; d_bits = 4'b0111; u = 16'h1357;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(posedge clk); #1;
      chk($sformatf("ep_in1_s%0d", k), {16'd0, ep_in1}, {16'd0, in1_bits[k] ? H_UM : H_ZERO});
      chk($sformatf("ep_in2_s%0d", k), {16'd0, ep_in2}, {16'd0, in2_bits[k] ? H_UM : H_ZERO});
      chk($sformatf("ep_d_s%0d", k), {16'd0, ep_d}, {16'd0, d_bits[k] ? H_UM : H_ZERO});
    end
    chk("ep_u", {16'd0, ep_u}, 32'h1357);
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("done_after_probe", {31'd0, done}, 32'd1);

    // Start pulse during APLICA of epoch 2 must not disturb the run
    apply(tbl[1], 10);

    // Reset in AVALIA of the first sample
    in1_bits = 4'b0101; in2_bits = 4'b0011; d_bits = 4'b0111;
    w0_ini = 16'h1234; w1_ini = 16'h5678; w2_ini = 16'h9ABC; mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_ep_in1", {16'd0, ep_in1}, 32'd0);
    chk("mid_ep_d", {16'd0, ep_d}, 32'd0);
    chk("mid_ep_w0", {16'd0, ep_w0}, 32'd0);
    chk("mid_cnt", {26'd0, epoca_cnt}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    apply(tbl[0], -1);

    // Behavioural step, OR function
    mode = 2; in1_bits = 4'b0101; in2_bits = 4'b0011; d_bits = 4'b0111;
    u = 16'h3800; w0_ini = 16'h0000; w1_ini = 16'h0000; w2_ini = 16'h0000;
    run(-1, n);
    chk("real_conv", {31'd0, convergiu}, 32'd1);
    chk("real_cnt_le32", {31'd0, (epoca_cnt <= 6'd32) && (epoca_cnt != 6'd0)}, 32'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("real_reapply_s%0d", k),
          {31'd0, step_y(ep_w0, ep_w1, ep_w2, bit2half(in1_bits[k]), bit2half(in2_bits[k]))},
          {31'd0, d_bits[k]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/treino_controlador.md
Name: treino_controlador

Overview:
- Training sequencer on the driving side of the single-sample perceptron training step (`epoca`).
- Each epoch it presents the 4 samples of a 2-input truth table, as IEEE754 half values, to `epoca`.
- After each sample it compares the step's output with the target, then writes the step's updated weights back into its weight registers.
- It repeats epochs until a full epoch has zero errors or an epoch limit is reached, then reports the final weights and status.

Parameters:
- MAX_EPOCAS, 32, maximum number of epochs before stopping without convergence.
- CNT_W, 6, width of the epoch counter; must satisfy 2^CNT_W > MAX_EPOCAS.
- LAT, 1, cycles a sample is held on the `ep_*` outputs before `ep_result`/`ep_w*_aux` are sampled; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin training; sampled only in IDLE or DONE.
- in1_bits  input  4  bit i = input 1 of sample i (OR example 4'b0101).
- in2_bits  input  4  bit i = input 2 of sample i (4'b0011).
- d_bits  input  4  bit i = target of sample i (OR 4'b0111).
- u  input  16  learning rate, half float, passed through to `ep_u`.
- w0_ini, w1_ini, w2_ini  input  16  initial weights, half float, loaded on start.
- ep_in1, ep_in2, ep_d  output  16  current sample to step: 16'h3C00 if bit=1, 16'h0000 if bit=0.
- ep_u  output  16  learning rate to step.
- ep_w0, ep_w1, ep_w2  output  16  current weight registers to step.
- ep_result  input  16  step output (16'h3C00 or 16'h0000).
- ep_w0_aux, ep_w1_aux, ep_w2_aux  input  16  updated weights from step.
- busy  output  1  high from LOAD through FIM_EPOCA.
- done  output  1  level, high in DONE; cleared on next accepted start.
- convergiu  output  1  valid when done: 1 means the last epoch had zero errors.
- epoca_cnt  output  CNT_W  number of completed epochs.
- erros_ult  output  3  error count of the last completed epoch, range 0..4.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All `ep_*` outputs, weight registers, busy, done, convergiu, epoca_cnt and erros_ult go to 0.
  - Sample index idx=0, latency counter=0, epoch error accumulator=0.
  - Reset mid-run aborts immediately; there is no resume.
- IDLE or DONE, start=1: go to LOAD. done and convergiu go to 0 in the same edge.
- LOAD (1 cycle):
  - Weights load from w0_ini..w2_ini.
  - epoca_cnt=0, idx=0, accumulator=0.
  - Next state APLICA.
- APLICA:
  - `ep_in1`/`ep_in2`/`ep_d` are driven from bit idx of in1_bits/in2_bits/d_bits.
  - Latency counter runs 0..LAT-1; at LAT-1 go to AVALIA.
- AVALIA (1 cycle):
  - Error when ep_result != ep_d (full 16-bit compare); if error, accumulator += 1.
  - Weight registers take ep_w0_aux..ep_w2_aux.
  - idx==3: idx=0, go to FIM_EPOCA. Otherwise idx+=1, go to APLICA.
- FIM_EPOCA (1 cycle):
  - erros_ult = accumulator; epoca_cnt += 1; accumulator cleared.
  - If accumulator==0: DONE with convergiu=1.
  - Else if epoca_cnt+1 == MAX_EPOCAS: DONE with convergiu=0.
  - Else: APLICA.
- DONE:
  - Weights, epoca_cnt, erros_ult and convergiu are held.
  - `ep_*` keep their last values.
- Timing:
  - Epoch length = 4*(LAT+1)+1 cycles.
  - Start-to-done = 1 + N_epochs*(4*(LAT+1)+1) cycles.
- Other rules:
  - start while busy is ignored.
  - in1_bits/in2_bits/d_bits/u changing while busy take effect at the next APLICA sample; the bench must hold them stable.
  - epoca_cnt never wraps: the stop condition fires before reaching 2^CNT_W.

Optional Feature:
- Macro: ATUALIZA_SO_ERRO_EN.
- Defined: in AVALIA, weight registers are written only when ep_result != ep_d; correct samples leave the weights untouched. This avoids half-float rounding drift on correct samples.
- Undefined: weights are written unconditionally in every AVALIA.

Decomposition:
- Shared package:
  - Half constants H_UM=16'h3C00, H_ZERO=16'h0000 (also used for the step's bias).
  - State encoding: IDLE, LOAD, APLICA, AVALIA, FIM_EPOCA, DONE.
- One sub-module, sel_amostra (combinational): bit vectors plus idx produce the three half-float sample values.

Test Plan:
- Stub step with ep_result=ep_d always, LAT=1 → done after 1+9=10 cycles; convergiu=1, epoca_cnt=1, erros_ult=0.
- Stub with ep_result=~target encoding always, MAX_EPOCAS=4 → done at cycle 1+4*9=37; convergiu=0, epoca_cnt=4, erros_ult=4.
- Real epoca integration:
  - Setup: OR data (4'b0101, 4'b0011, 4'b0111), w*_ini=16'h0000, u=16'h3800.
  - Required: convergiu=1, epoca_cnt ≤ 32.
  - Required: final weights reproduce d=0,1,1,1 when re-applied.
- Pulse start in APLICA of epoch 2 → ignored; run finishes at the same cycle as a run without the extra pulse.
- Assert reset=0 during AVALIA → same cycle, busy=0, all outputs 0, state IDLE; start after release runs a full fresh sequence.
- Stub returning ep_w*_aux=16'h4000 with ep_result=ep_d:
  - ATUALIZA_SO_ERRO_EN defined: weights stay at w*_ini.
  - Undefined: weights become 16'h4000.
